// File: rtl/seg_scan_capture.sv
// Receive-side capture of a scanned multiplexed 7-segment display: decodes each digit and
// publishes complete frames atomically. Optional input synchronizer: SEG_SCAN_SYNC_EN.
module seg_scan_capture #(
  parameter int unsigned NUM_DIG    = 6,
  parameter int unsigned SETTLE_CYC = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [6:0]             i_seg,
  input  logic                   i_seg_dp,
  input  logic [NUM_DIG-1:0]     i_seg_enb,
  output logic [4*NUM_DIG-1:0]   o_digits,
  output logic [NUM_DIG-1:0]     o_dp,
  output logic                   o_valid,
  output logic                   o_err,
  output logic [7:0]             o_frame_cnt
);

  localparam int unsigned SW = 8 + NUM_DIG;
  localparam int unsigned DW = 4 * NUM_DIG;
  localparam logic [7:0]  SETTLE_V = 8'(SETTLE_CYC);
  localparam logic [SW-1:0] S_RST = {8'h00, {NUM_DIG{1'b1}}};

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_HOLD} state_e;

  state_e              state_q, state_d;
  logic [SW-1:0]       s_c, prev_q;
  logic [7:0]          cnt_q, cnt_d;
  logic                change_c, capture_c, one_cold_c;
  logic [6:0]          seg_c;
  logic                dp_c;
  logic [NUM_DIG-1:0]  enb_c;
  logic [3:0]          dec_c;
  logic [NUM_DIG-1:0]  mask_q, mask_d, sh_dp_q, sh_dp_d, dp_q, dp_d;
  logic [DW-1:0]       sh_dig_q, sh_dig_d, digits_q, digits_d;
  logic [7:0]          frame_cnt_q, frame_cnt_d;
  logic                valid_q, valid_d, err_q, err_d;

`ifdef SEG_SCAN_SYNC_EN
  logic [SW-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= S_RST;
      sync2_q <= S_RST;
    end else begin
      sync1_q <= {i_seg, i_seg_dp, i_seg_enb};
      sync2_q <= sync1_q;
    end
  end

  assign s_c = sync2_q;
`else
  assign s_c = {i_seg, i_seg_dp, i_seg_enb};
`endif

  assign seg_c      = s_c[SW-1 -: 7];
  assign dp_c       = s_c[NUM_DIG];
  assign enb_c      = s_c[NUM_DIG-1:0];
  assign one_cold_c = $onehot(~enb_c);
  assign change_c   = (s_c != prev_q);
  assign dec_c      = seg_decode(seg_c);

  function automatic logic [3:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'h7E:   seg_decode = 4'h0;
      7'h30:   seg_decode = 4'h1;
      7'h6D:   seg_decode = 4'h2;
      7'h79:   seg_decode = 4'h3;
      7'h33:   seg_decode = 4'h4;
      7'h5B:   seg_decode = 4'h5;
      7'h5F:   seg_decode = 4'h6;
      7'h70:   seg_decode = 4'h7;
      7'h7F:   seg_decode = 4'h8;
      7'h7B:   seg_decode = 4'h9;
      7'h00:   seg_decode = 4'hF;
      default: seg_decode = 4'hE;
    endcase
  endfunction

  // Stability counter: 1 on the cycle S changes, then counts up to SETTLE_CYC.
  always_comb begin
    cnt_d = cnt_q;
    if (change_c)             cnt_d = 8'd1;
    else if (cnt_q < SETTLE_V) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      prev_q  <= S_RST;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      prev_q  <= s_c;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    capture_c = 1'b0;
    case (state_q)
      ST_IDLE: if (change_c) state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (change_c) begin
          state_d = ST_SETTLE;
        end else if (cnt_d == SETTLE_V) begin
          capture_c = one_cold_c;
          state_d   = one_cold_c ? ST_HOLD : ST_IDLE;
        end
      end
      ST_HOLD: if (change_c) state_d = ST_SETTLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Commit clears the mask first so a same-cycle capture starts the next frame.
  always_comb begin
    mask_d      = mask_q;
    sh_dig_d    = sh_dig_q;
    sh_dp_d     = sh_dp_q;
    digits_d    = digits_q;
    dp_d        = dp_q;
    frame_cnt_d = frame_cnt_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    if (&mask_q) begin
      digits_d    = sh_dig_q;
      dp_d        = sh_dp_q;
      valid_d     = 1'b1;
      frame_cnt_d = frame_cnt_q + 8'd1;
      mask_d      = '0;
    end
    if (capture_c) begin
      err_d = (dec_c == 4'hE);
      for (int k = 0; k < NUM_DIG; k++) begin
        if (!enb_c[k]) begin
          mask_d[k]         = 1'b1;
          sh_dig_d[4*k +: 4] = dec_c;
          sh_dp_d[k]        = dp_c;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q      <= '0;
      sh_dig_q    <= '0;
      sh_dp_q     <= '0;
      digits_q    <= '0;
      dp_q        <= '0;
      frame_cnt_q <= 8'd0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mask_q      <= mask_d;
      sh_dig_q    <= sh_dig_d;
      sh_dp_q     <= sh_dp_d;
      digits_q    <= digits_d;
      dp_q        <= dp_d;
      frame_cnt_q <= frame_cnt_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  assign o_digits    = digits_q;
  assign o_dp        = dp_q;
  assign o_valid     = valid_q;
  assign o_err       = err_q;
  assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Randomized self-checking bench for seg_scan_capture against a step-level frame model.
module tb_seg_scan_capture;

  localparam int unsigned NUM_DIG = 6;
  localparam int unsigned SETTLE  = 16;
`ifdef SEG_SCAN_SYNC_EN
  localparam int unsigned SYNC_LAT = 2;
`else
  localparam int unsigned SYNC_LAT = 0;
`endif
  localparam int unsigned CAP_LAT = SETTLE + SYNC_LAT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  i_seg = '0;
  logic        i_seg_dp = 1'b0;
  logic [5:0]  i_seg_enb = '1;
  logic [23:0] o_digits;
  logic [5:0]  o_dp;
  logic        o_valid;
  logic        o_err;
  logic [7:0]  o_frame_cnt;

  seg_scan_capture #(.NUM_DIG(NUM_DIG), .SETTLE_CYC(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .i_seg(i_seg), .i_seg_dp(i_seg_dp), .i_seg_enb(i_seg_enb),
    .o_digits(o_digits), .o_dp(o_dp), .o_valid(o_valid), .o_err(o_err),
    .o_frame_cnt(o_frame_cnt)
  );

  always #10 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: a digit step counts only if held >= SETTLE with exactly one enable low.
  typedef struct {
    int unsigned at;
    logic [23:0] dig;
    logic [5:0]  dp;
    logic [7:0]  cnt;
  } commit_t;

  logic [6:0]  pat_tab [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
  commit_t     vq[$];
  int unsigned eq[$];
  logic [3:0]  m_dig [NUM_DIG];
  logic        m_dp  [NUM_DIG];
  bit          m_have[NUM_DIG];
  int          m_frames = 0;
  int          m_commits = 0;
  int          n_valid_seen = 0;
  logic [13:0] last_s = {8'h00, 6'h3F};

  function automatic logic [3:0] ref_decode(input logic [6:0] p);
    for (int i = 0; i < 10; i++) if (p == pat_tab[i]) return 4'(i);
    if (p == 7'h00) return 4'hF;
    return 4'hE;
  endfunction

  function automatic logic [5:0] enb_for(input int k);
    logic [5:0] e;
    e = '1;
    e[k] = 1'b0;
    return e;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NUM_DIG; k++) m_have[k] = 1'b0;
    m_frames = 0;
  endfunction

  function automatic void model_step(input int unsigned start, input logic [6:0] seg,
                                     input logic dp, input logic [5:0] enb, input int unsigned hold);
    int      k;
    bit      full;
    commit_t c;
    if (hold < SETTLE || $countones(~enb) != 1) return;
    k = 0;
    for (int i = 0; i < NUM_DIG; i++) if (!enb[i]) k = i;
    m_dig[k]  = ref_decode(seg);
    m_dp[k]   = dp;
    m_have[k] = 1'b1;
    if (m_dig[k] == 4'hE) eq.push_back(start + CAP_LAT);
    full = 1'b1;
    for (int i = 0; i < NUM_DIG; i++) full &= m_have[i];
    if (full) begin
      m_frames = (m_frames + 1) % 256;
      m_commits++;
      for (int i = 0; i < NUM_DIG; i++) begin
        c.dig[4*i +: 4] = m_dig[i];
        c.dp[i]         = m_dp[i];
        m_have[i]       = 1'b0;
      end
      c.at  = start + CAP_LAT + 1;
      c.cnt = 8'(m_frames);
      vq.push_back(c);
    end
  endfunction

  // Called at a negedge; drives one scan step and holds it for `hold` cycles.
  task automatic apply_step(input logic [6:0] seg, input logic dp, input logic [5:0] enb,
                            input int unsigned hold);
    i_seg = seg;
    i_seg_dp = dp;
    i_seg_enb = enb;
    last_s = {seg, dp, enb};
    model_step(cyc, seg, dp, enb, hold);
    repeat (hold) @(negedge clk);
  endtask

  logic exp_v, exp_e;
  always @(negedge clk) begin
    exp_v = (vq.size() > 0) && (vq[0].at == cyc);
    chk("valid", 32'(o_valid), 32'(exp_v));
    if (exp_v) begin
      chk("digits", 32'(o_digits), 32'(vq[0].dig));
      chk("dp", 32'(o_dp), 32'(vq[0].dp));
      chk("frame_cnt", 32'(o_frame_cnt), 32'(vq[0].cnt));
      void'(vq.pop_front());
    end
    if (o_valid) n_valid_seen++;
    exp_e = (eq.size() > 0) && (eq[0] == cyc);
    chk("err", 32'(o_err), 32'(exp_e));
    if (exp_e) void'(eq.pop_front());
  end

  int          base_commits, base_seen, steps, k, r;
  logic [6:0]  seg;
  logic        dp;
  logic [5:0]  enb;
  int unsigned hold;

  initial begin
    model_reset();
    i_seg = 7'($urandom);
    i_seg_dp = 1'($urandom);
    i_seg_enb = 6'($urandom);
    repeat (3) @(negedge clk);
    chk("rst_digits", 32'(o_digits), 32'h0);
    chk("rst_dp", 32'(o_dp), 32'h0);
    chk("rst_valid", 32'(o_valid), 32'h0);
    chk("rst_err", 32'(o_err), 32'h0);
    chk("rst_cnt", 32'(o_frame_cnt), 32'h0);
    i_seg = '0; i_seg_dp = 1'b0; i_seg_enb = 6'h3F;
    @(negedge clk);
    rst_n = 1'b1;
    apply_step(7'h00, 1'b0, 6'h3F, 100);
    chk("idle_cnt", 32'(o_frame_cnt), 32'h0);
    chk("idle_pulses", 32'(n_valid_seen), 32'h0);

    // Full frame 654321 with dp on digit 2
    for (int d = 0; d < 6; d++) apply_step(pat_tab[d+1], d == 2, enb_for(d), 100);
    chk("ff_digits", 32'(o_digits), 32'h654321);
    chk("ff_dp", 32'(o_dp), 32'b000100);
    chk("ff_cnt", 32'(o_frame_cnt), 32'h1);

    // Short glitch on digit 3 must not be captured
    for (int d = 0; d < 3; d++) apply_step(pat_tab[d+1], 1'b0, enb_for(d), 100);
    apply_step(7'h7F, 1'b0, enb_for(3), 10);
    apply_step(7'h33, 1'b0, enb_for(3), 100);
    apply_step(pat_tab[5], 1'b0, enb_for(4), 100);
    apply_step(pat_tab[6], 1'b0, enb_for(5), 100);
    chk("gl_d3", 32'(o_digits[15:12]), 32'h4);
    chk("gl_cnt", 32'(o_frame_cnt), 32'h2);

    // Two enables low, undecodable pattern, blank pattern
    apply_step(pat_tab[8], 1'b0, 6'h3C, 100);
    apply_step(7'h01, 1'b0, enb_for(0), 100);
    apply_step(7'h00, 1'b1, enb_for(1), 100);
    for (int d = 2; d < 6; d++) apply_step(pat_tab[d], 1'b0, enb_for(d), 100);
    chk("inv_d0", 32'(o_digits[3:0]), 32'hE);
    chk("inv_d1", 32'(o_digits[7:4]), 32'hF);
    chk("inv_cnt", 32'(o_frame_cnt), 32'h3);

    // Random scans until 256 further frames commit (frame counter wraps)
    base_commits = m_commits;
    base_seen = n_valid_seen;
    steps = 0;
    while (m_commits - base_commits < 256 && steps < 5000) begin
      steps++;
      r = int'($urandom_range(0, 15));
      if (r == 0) begin
        enb = '1;
        if ($urandom_range(0, 1) == 1) begin
          k = int'($urandom_range(0, 5));
          enb[k] = 1'b0;
          enb[(k + 1 + int'($urandom_range(0, 4))) % 6] = 1'b0;
        end
      end else begin
        k = 0;
        while (k < 5 && m_have[k]) k++;
        if ($urandom_range(0, 3) == 0) k = int'($urandom_range(0, 5));
        enb = enb_for(k);
      end
      seg = ($urandom_range(0, 7) == 0) ? 7'($urandom) : pat_tab[$urandom_range(0, 9)];
      dp = 1'($urandom);
      if ({seg, dp, enb} == last_s) dp = ~dp;
      case ($urandom_range(0, 7))
        0: hold = SETTLE - 1;
        1: hold = SETTLE;
        2: hold = $urandom_range(2, SETTLE - 2);
        default: hold = SETTLE + $urandom_range(1, 12);
      endcase
      apply_step(seg, dp, enb, hold);
    end
    apply_step(7'h00, 1'b0, 6'h3F, 100);
    chk("wrap_pulses", 32'(n_valid_seen - base_seen), 32'd256);
    chk("wrap_cnt", 32'(o_frame_cnt), 32'(m_frames));

    // Reset after three captured digits discards the partial frame
    for (int d = 0; d < 3; d++) apply_step(pat_tab[7+d], 1'b0, enb_for(d), 100);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    chk("mr_digits", 32'(o_digits), 32'h0);
    chk("mr_dp", 32'(o_dp), 32'h0);
    chk("mr_cnt0", 32'(o_frame_cnt), 32'h0);
    i_seg = '0; i_seg_dp = 1'b0; i_seg_enb = 6'h3F;
    last_s = {8'h00, 6'h3F};
    @(negedge clk);
    rst_n = 1'b1;
    apply_step(7'h00, 1'b0, 6'h3F, 50);
    base_seen = n_valid_seen;
    for (int d = 3; d < 6; d++) apply_step(pat_tab[d], 1'b0, enb_for(d), 100);
    chk("mr_nopulse", 32'(n_valid_seen - base_seen), 32'h0);
    for (int d = 0; d < 3; d++) apply_step(pat_tab[d], 1'b1, enb_for(d), 100);
    chk("mr_digits2", 32'(o_digits), 32'h543210);
    chk("mr_cnt1", 32'(o_frame_cnt), 32'h1);

    chk("pending_valid", 32'(vq.size()), 32'h0);
    chk("pending_err", 32'(eq.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
- Receive-side counterpart of the multiplexed 6-digit 7-segment display driver.
- Watches the scanned segment, decimal-point and digit-enable lines and decodes each digit's segment pattern back to a 4-bit code.
- Assembles a complete 6-digit frame and publishes it atomically with a one-cycle valid pulse.
- Used for on-chip self-check of the display path and as a bench monitor in display top-level tests.

Parameters:
- NUM_DIG, 6, number of scanned digits (widths below scale with it).
- SETTLE_CYC, 16, consecutive cycles the sampled inputs must stay unchanged before a digit is captured; legal range 2..255.

Ports:
- clk  input  1  system clock (50 MHz nominal).
- rst_n  input  1  reset, asynchronous, active-low.
- i_seg  input  7  segment lines, active-high; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
- i_seg_dp  input  1  decimal point, active-high.
- i_seg_enb  input  NUM_DIG  digit enables, active-low one-cold; bit0 = rightmost digit.
- o_digits  output  4*NUM_DIG  decoded frame; o_digits[4k+3:4k] = digit k.
- o_dp  output  NUM_DIG  decimal point per digit of the last frame.
- o_valid  output  1  one-cycle pulse when o_digits/o_dp are updated.
- o_err  output  1  one-cycle pulse when an undecodable segment pattern is captured.
- o_frame_cnt  output  8  count of completed frames, wraps 255->0.

Behaviour:
- Reset (async assert, sync release on clk): o_digits=0, o_dp=0, o_valid=0, o_err=0, o_frame_cnt=0. Shadow registers, captured mask, stability counter and FSM are all cleared; FSM goes to IDLE.
- Sampled vector S = {i_seg, i_seg_dp, i_seg_enb} (after the optional sync stage). A stability counter resets to 1 whenever S differs from its previous-cycle value; otherwise it increments, saturating at SETTLE_CYC.
- FSM:
  - IDLE: S has not been stable long enough or has been rejected. Move to SETTLE when S changes.
  - SETTLE: counting. When the counter reaches SETTLE_CYC:
    - If i_seg_enb has exactly one bit low, capture and go to HOLD.
    - Otherwise (no bit low, or more than one low) discard the sample and go to IDLE.
    - A change in S before the counter reaches SETTLE_CYC restarts SETTLE.
  - HOLD: exactly one capture has been made for this stable interval; stay until S changes, then go to SETTLE.
- Capture for digit k:
  - Write shadow_dig[k] = decode(i_seg), shadow_dp[k] = i_seg_dp, and set mask[k].
  - Re-capturing a digit before frame completion overwrites its shadow entry; the mask bit is unchanged.
- Decode table (i_seg hex -> code):
  - 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7, 7F->8, 7B->9.
  - 00 (blank) -> F.
  - Any other pattern -> E, and o_err pulses the cycle after the capture.
- Frame commit:
  - On the cycle after the capture that makes mask all-ones: copy the shadows to o_digits/o_dp, pulse o_valid, increment o_frame_cnt and clear the mask.
  - A capture arriving on the commit cycle is applied after the clear, so it becomes the first digit of the next frame.
- Latency: the last digit's capture happens SETTLE_CYC cycles after S settles; o_valid follows 1 cycle later (plus 2 cycles when sync is enabled).
- Outputs hold their values between commits. A reset mid-frame discards the partial frame.

Optional Feature:
- Macro SEG_SCAN_SYNC_EN.
- Defined: i_seg, i_seg_dp and i_seg_enb each pass through a 2-flop synchronizer (reset value: seg 0, dp 0, enb all-ones) before stability detection. Total latency increases by 2 cycles. Use this when the inputs come from pins or another clock domain.
- Undefined: inputs are sampled directly (same-clock source); no extra latency.

Test Plan:
- Reset: hold rst_n=0 with arbitrary inputs -> all outputs 0. Release with i_seg_enb=6'h3F for 100 cycles -> o_valid never pulses, o_frame_cnt=0.
- Full frame: drive digit k (enb bit k low) with the pattern for value k+1, each held 100 cycles, dp only on digit 2 -> exactly one o_valid pulse, o_digits=24'h654321, o_dp=6'b000100, o_frame_cnt=1.
- Glitch rejection: insert a 10-cycle enable for digit 3 showing 7F between legitimate digits -> no capture of the glitch. Then drive the normal frame (digit 3 held 100 cycles showing 33) -> the committed digit 3 = 4, not 8.
- Invalid enable/pattern: hold enb=6'h3C (two low) for 100 cycles -> no capture. Drive digit 0 with pattern 01 -> o_err pulses once and that frame's digit 0 = E. Drive digit 1 with pattern 00 -> digit 1 = F.
- Wrap and reset mid-frame: run 256 frames -> o_frame_cnt wraps to 0 and o_valid pulses 256 times. Assert rst_n after 3 captured digits -> outputs clear, and the next frame requires all 6 digits before o_valid.
- With SEG_SCAN_SYNC_EN defined, repeat the full-frame scenario -> identical values, and o_valid arrives exactly 2 cycles later than without the macro.
